// File: rtl/motor_pwm_ctrl_if.sv
// Command bus into motor_pwm_ctrl: per-channel write strobe, duty target and direction.
// The host drives the master side; the PWM controller samples the slave side.
interface motor_pwm_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       cmd_we;
  logic [NUM_CH*CNT_W-1:0] cmd_duty;
  logic [NUM_CH-1:0]       cmd_dir;

  modport master (output cmd_we, cmd_duty, cmd_dir);
  modport slave  (input  cmd_we, cmd_duty, cmd_dir);
endinterface

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel H-bridge PWM/direction driver; duty updates at period boundaries, dead time on reversal.
// Define MOTOR_PWM_RAMP_EN for soft start/stop (duty moves one step per period).
module motor_pwm_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 100,
  parameter int DEAD_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  motor_pwm_ctrl_if.slave   cmd,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] in1_o,
  output logic [NUM_CH-1:0] in2_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic              period_start_o
);
  // Duty needs one extra bit so that PERIOD == 2^CNT_W (constant high) is representable.
  localparam int DW  = CNT_W + 1;
  localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [DW-1:0]    DUTY_MAX  = DW'(PERIOD);
  localparam logic [DCW-1:0]   DEAD_INIT = DCW'(DEAD_CYC - 1);

  typedef enum logic [1:0] {S_RUN, S_DEAD, S_ARM} state_e;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              boundary;
  state_e            state_q    [NUM_CH];
  logic [DW-1:0]     duty_act_q [NUM_CH];
  logic [DW-1:0]     tgt_duty_q [NUM_CH];
  logic [DW-1:0]     tgt_duty_d [NUM_CH];
  logic [DW-1:0]     duty_step  [NUM_CH];
  logic [DCW-1:0]    dead_q     [NUM_CH];
  logic [NUM_CH-1:0] dir_act_q, tgt_dir_q, tgt_dir_d, duty_diff;
  logic [NUM_CH-1:0] pwm_q, in1_q, in2_q, busy_q;
  logic              period_start_q;

  always_comb begin
    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_duty_d[k] = tgt_duty_q[k];
      tgt_dir_d[k]  = tgt_dir_q[k];
      if (cmd.cmd_we[k]) begin
        tgt_duty_d[k] = ({1'b0, cmd.cmd_duty[k*CNT_W +: CNT_W]} >= DUTY_MAX) ?
                        DUTY_MAX : {1'b0, cmd.cmd_duty[k*CNT_W +: CNT_W]};
        tgt_dir_d[k]  = cmd.cmd_dir[k];
      end
`ifdef MOTOR_PWM_RAMP_EN
      if (duty_act_q[k] < tgt_duty_q[k])      duty_step[k] = duty_act_q[k] + 1'b1;
      else if (duty_act_q[k] > tgt_duty_q[k]) duty_step[k] = duty_act_q[k] - 1'b1;
      else                                    duty_step[k] = duty_act_q[k];
      duty_diff[k] = (duty_act_q[k] != tgt_duty_q[k]);
`else
      duty_step[k] = tgt_duty_q[k];
      duty_diff[k] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      pwm_q          <= '0;
      in1_q          <= '0;
      in2_q          <= '0;
      busy_q         <= '0;
      dir_act_q      <= '1;
      tgt_dir_q      <= '1;
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k]    <= S_RUN;
        duty_act_q[k] <= '0;
        tgt_duty_q[k] <= '0;
        dead_q[k]     <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= (cnt_q == '0);
      tgt_dir_q      <= tgt_dir_d;
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_duty_q[k] <= tgt_duty_d[k];
        pwm_q[k]  <= (state_q[k] == S_RUN) && ({1'b0, cnt_q} < duty_act_q[k]);
        in1_q[k]  <= (state_q[k] != S_DEAD) && dir_act_q[k];
        in2_q[k]  <= (state_q[k] != S_DEAD) && !dir_act_q[k];
        busy_q[k] <= (state_q[k] != S_RUN) || (tgt_dir_q[k] != dir_act_q[k]) || duty_diff[k];
        case (state_q[k])
          S_RUN: begin
            if (boundary) begin
              if (tgt_dir_q[k] == dir_act_q[k]) begin
                duty_act_q[k] <= duty_step[k];
`ifdef MOTOR_PWM_RAMP_EN
              end else if (duty_act_q[k] != '0) begin
                // Spin down before the bridge is released for reversal.
                duty_act_q[k] <= duty_act_q[k] - 1'b1;
`endif
              end else begin
                state_q[k] <= S_DEAD;
                dead_q[k]  <= DEAD_INIT;
              end
            end
          end
          S_DEAD: begin
            if (dead_q[k] == '0) begin
              dir_act_q[k]  <= tgt_dir_q[k];
              duty_act_q[k] <= '0;
              state_q[k]    <= S_ARM;
            end else begin
              dead_q[k] <= dead_q[k] - 1'b1;
            end
          end
          S_ARM: begin
            if (boundary) begin
              duty_act_q[k] <= duty_step[k];
              state_q[k]    <= S_RUN;
            end
          end
          default: state_q[k] <= S_RUN;
        endcase
      end
    end
  end

  assign pwm_o          = pwm_q;
  assign in1_o          = in1_q;
  assign in2_o          = in2_q;
  assign busy_o         = busy_q;
  assign period_start_o = period_start_q;
endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Bench for motor_pwm_ctrl: directed plan steps then random commands, checked every cycle against a reference model.
module tb_motor_pwm_ctrl;
  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;
  localparam int PERIOD   = 10;
  localparam int DEAD_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] pwm_o, in1_o, in2_o, busy_o;
  logic              period_start_o;

  motor_pwm_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  motor_pwm_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst(rst), .cmd(bus),
    .pwm_o(pwm_o), .in1_o(in1_o), .in2_o(in2_o), .busy_o(busy_o),
    .period_start_o(period_start_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: m_dead counts dead cycles still to serve (0 = not in dead time).
  int m_cnt;
  int m_duty [NUM_CH];
  int m_tduty[NUM_CH];
  bit m_dir  [NUM_CH];
  bit m_tdir [NUM_CH];
  int m_dead [NUM_CH];
  bit m_arm  [NUM_CH];
  logic [NUM_CH-1:0] e_pwm, e_in1, e_in2, e_busy;
  logic              e_ps;

  function automatic int toward(input int cur, input int tgt);
`ifdef MOTOR_PWM_RAMP_EN
    return cur + int'(tgt > cur) - int'(tgt < cur);
`else
    return tgt;
`endif
  endfunction

  task automatic model_step();
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_duty[k] = 0; m_tduty[k] = 0; m_dir[k] = 1; m_tdir[k] = 1;
        m_dead[k] = 0; m_arm[k] = 0;
      end
      e_pwm = '0; e_in1 = '0; e_in2 = '0; e_busy = '0; e_ps = 1'b0;
    end else begin
      e_ps = (m_cnt == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        bit running;
        running   = (m_dead[k] == 0) && !m_arm[k];
        e_pwm[k]  = running && (m_cnt < m_duty[k]);
        e_in1[k]  = (m_dead[k] == 0) && m_dir[k];
        e_in2[k]  = (m_dead[k] == 0) && !m_dir[k];
        e_busy[k] = !running || (m_tdir[k] != m_dir[k]);
`ifdef MOTOR_PWM_RAMP_EN
        if (m_duty[k] != m_tduty[k]) e_busy[k] = 1'b1;
`endif
        if (m_dead[k] > 0) begin
          m_dead[k]--;
          if (m_dead[k] == 0) begin
            m_dir[k] = m_tdir[k]; m_duty[k] = 0; m_arm[k] = 1;
          end
        end else if (m_cnt == PERIOD - 1) begin
          if (m_arm[k]) begin
            m_duty[k] = toward(m_duty[k], m_tduty[k]); m_arm[k] = 0;
          end else if (m_tdir[k] == m_dir[k]) begin
            m_duty[k] = toward(m_duty[k], m_tduty[k]);
`ifdef MOTOR_PWM_RAMP_EN
          end else if (m_duty[k] > 0) begin
            m_duty[k]--;
`endif
          end else begin
            m_dead[k] = DEAD_CYC;
          end
        end
        if (bus.cmd_we[k]) begin
          m_tduty[k] = int'(bus.cmd_duty[k*CNT_W +: CNT_W]);
          if (m_tduty[k] > PERIOD) m_tduty[k] = PERIOD;
          m_tdir[k] = bus.cmd_dir[k];
        end
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("period_start", 8'(period_start_o), 8'(e_ps));
    chk("pwm",  8'(pwm_o),  8'(e_pwm));
    chk("in1",  8'(in1_o),  8'(e_in1));
    chk("in2",  8'(in2_o),  8'(e_in2));
    chk("busy", 8'(busy_o), 8'(e_busy));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input int ch, input int duty, input bit dir);
    bus.cmd_we                         = '0;
    bus.cmd_we[ch]                     = 1'b1;
    bus.cmd_duty[ch*CNT_W +: CNT_W]    = CNT_W'(duty);
    bus.cmd_dir[ch]                    = dir;
    cycle();
    bus.cmd_we = '0;
  endtask

  // sel 0 counts pwm high cycles, sel 1 counts cycles with both bridge inputs low.
  task automatic count_sig(input int ch, input int sel, input int n, output int c);
    c = 0;
    repeat (n) begin
      cycle();
      if (sel == 0) c += int'(pwm_o[ch]);
      else          c += int'(!in1_o[ch] && !in2_o[ch]);
    end
  endtask

  task automatic wait_cnt(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 3 * PERIOD) begin
      cycle();
      guard++;
    end
    chk("align_timeout", 8'(guard < 3 * PERIOD), 8'd1);
  endtask

  initial begin
    int c;
    int guard;
    rst          = 1'b1;
    bus.cmd_we   = '0;
    bus.cmd_duty = '0;
    bus.cmd_dir  = '1;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Plan 1: duty 7 forward on ch0.
    wr(0, 7, 1'b1);
    idle(25);
    count_sig(0, 0, PERIOD, c);
    chk("t1_high_cycles", 8'(c), 8'd7);
    chk("t1_in1", 8'(in1_o[0]), 8'd1);
    chk("t1_in2", 8'(in2_o[0]), 8'd0);

    // Plan 2: clamp to constant high, then constant low; ch0 untouched.
    wr(1, 15, 1'b1);
    idle(20);
    count_sig(1, 0, PERIOD, c);
    chk("t2_clamp_high", 8'(c), 8'd10);
    wr(1, 0, 1'b1);
    idle(20);
    count_sig(1, 0, PERIOD, c);
    chk("t2_zero_low", 8'(c), 8'd0);
    count_sig(0, 0, PERIOD, c);
    chk("t2_ch0_undisturbed", 8'(c), 8'd7);

    // Plan 3: reversal with dead time.
    wr(0, 5, 1'b1);
    idle(25);
    wr(0, 5, 1'b0);
    count_sig(0, 1, 30, c);
    chk("t3_dead_cycles", 8'(c), 8'd4);
    idle(20);
    count_sig(0, 0, PERIOD, c);
    chk("t3_high_after_rev", 8'(c), 8'd5);
    chk("t3_in2_reverse", 8'(in2_o[0]), 8'd1);

    // Plan 4: last write wins; write on the boundary cycle lands a period later.
    wait_cnt(1);
    wr(0, 3, 1'b0);
    idle(1);
    wr(0, 8, 1'b0);
    idle(20);
    count_sig(0, 0, PERIOD, c);
    chk("t4_last_write", 8'(c), 8'd8);
    wait_cnt(PERIOD - 1);
    wr(0, 2, 1'b0);
    count_sig(0, 0, PERIOD, c);
    chk("t4_boundary_write_old", 8'(c), 8'd8);
    count_sig(0, 0, PERIOD, c);
    chk("t4_boundary_write_new", 8'(c), 8'd2);

    // Plan 5: reset during dead time.
    wr(0, 4, 1'b1);
    guard = 0;
    while (m_dead[0] == 0 && guard < 3 * PERIOD) begin
      cycle();
      guard++;
    end
    chk("t5_dead_timeout", 8'(guard < 3 * PERIOD), 8'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_pwm_zero",  8'(pwm_o),  8'd0);
    chk("t5_in1_zero",  8'(in1_o),  8'd0);
    chk("t5_busy_zero", 8'(busy_o), 8'd0);
    idle(3);
    chk("t5_dir_fwd", 8'(in1_o[0]), 8'd1);

    // Random commands, reversals and occasional resets.
    repeat (1500) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        bus.cmd_we[k] = ($urandom_range(0, 7) == 0);
        bus.cmd_duty[k*CNT_W +: CNT_W] = ($urandom_range(0, 3) == 0) ?
            CNT_W'($urandom_range(0, 255)) : CNT_W'($urandom_range(0, 11));
        bus.cmd_dir[k] = 1'($urandom_range(0, 1));
      end
      cycle();
      bus.cmd_we = '0;
      rst        = 1'b0;
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
